fire_expand3_engine: RTL and testbench

Parametrised 3×3 expand-convolution engine generalising the per-layer fire expand blocks into a single core. It is time-shared by any number of fire layers, selected per run with `layer_sel`. It streams one input pixel per accepted cycle into a DSP_NO-wide signed MAC array. For each output pixel it adds bias, applies ReLU and saturating requantisation, then presents all channels with a valid/ready handshake. It sits between the squeeze-layer RAM reader and the expand output RAM. Kernel and bias ROM wrappers are addressed from `cur_layer`/`kernel_addr`.

---
 rtl/fire_expand3_engine.sv | 129 ++++++++++++
 tb/tb_fire_expand3_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fire_expand3_engine.sv
// Shared 3x3 expand-convolution core: streams taps into a DSP_NO-wide MAC
// array, then biases, ReLUs and saturates each output pixel.
module fire_expand3_engine #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 14,
    parameter int DSP_NO     = 128,
    parameter int CHIN       = 32,
    parameter int KERNEL_DIM = 3,
    parameter int WOUT       = 32,
    parameter int NLAYERS    = 2,
    localparam int TAPS      = KERNEL_DIM * KERNEL_DIM * CHIN,
    localparam int PIXELS    = WOUT * WOUT,
    localparam int LW        = (NLAYERS > 1) ? $clog2(NLAYERS) : 1,
    localparam int AW        = $clog2(TAPS),
    localparam int ACCW      = 2 * WIDTH + $clog2(TAPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LW-1:0]              layer_sel,
    output logic [LW-1:0]              cur_layer,
    output logic                       busy,
    output logic                       done,
    input  logic [WIDTH-1:0]           ifm,
    input  logic                       ifm_valid,
    output logic                       ifm_ready,
    output logic [AW-1:0]              kernel_addr,
    input  logic [DSP_NO*WIDTH-1:0]    kernels,
    input  logic [DSP_NO*2*WIDTH-1:0]  bias,
    output logic [DSP_NO*WIDTH-1:0]    ofm,
    output logic                       ofm_valid,
    input  logic                       ofm_ready
);

    localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
    localparam logic [PW-1:0] LAST_PIX = PW'(PIXELS - 1);

    typedef enum logic [2:0] {IDLE, ACC, REQ, OUT, DONE} state_t;

    state_t state, state_nxt;
    logic [PW-1:0] pixel;

    logic signed [ACCW-1:0]    acc  [DSP_NO];
    logic signed [ACCW-1:0]    term [DSP_NO];
    logic signed [2*WIDTH-1:0] opa  [DSP_NO];
    logic signed [2*WIDTH-1:0] opb  [DSP_NO];
    logic signed [2*WIDTH-1:0] prod [DSP_NO];
    logic signed [ACCW:0]      s    [DSP_NO];
    logic signed [ACCW:0]      q    [DSP_NO];
    logic [WIDTH-1:0]          rq   [DSP_NO];

    wire last_tap = (kernel_addr == LAST_TAP);
    wire last_pix = (pixel == LAST_PIX);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = ACC;
            ACC:  if (ifm_valid && last_tap) state_nxt = REQ;
            REQ:  state_nxt = OUT;
            OUT:  if (ofm_ready) state_nxt = last_pix ? DONE : ACC;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        ifm_ready = (state == ACC);
        ofm_valid = (state == OUT);
        done      = (state == DONE);
    end

    // Full-precision product and bias sum; requantise only after ReLU.
    always_comb begin
        for (int i = 0; i < DSP_NO; i++) begin
            opa[i]  = {{WIDTH{ifm[WIDTH-1]}}, ifm};
            opb[i]  = {{WIDTH{kernels[i*WIDTH+WIDTH-1]}},
                       kernels[i*WIDTH +: WIDTH]};
            prod[i] = opa[i] * opb[i];
            term[i] = {{(ACCW-2*WIDTH){prod[i][2*WIDTH-1]}}, prod[i]};
            s[i]    = {acc[i][ACCW-1], acc[i]} +
                      {{(ACCW+1-2*WIDTH){bias[i*2*WIDTH+2*WIDTH-1]}},
                       bias[i*2*WIDTH +: 2*WIDTH]};
            q[i]    = s[i] >>> FRAC;
            if (s[i][ACCW])
                rq[i] = '0;
            else if (|q[i][ACCW:WIDTH-1])
                rq[i] = {1'b0, {(WIDTH-1){1'b1}}};
            else
                rq[i] = q[i][WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_layer   <= '0;
            kernel_addr <= '0;
            pixel       <= '0;
            ofm         <= '0;
            for (int i = 0; i < DSP_NO; i++) acc[i] <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    cur_layer   <= layer_sel;
                    kernel_addr <= '0;
                    pixel       <= '0;
                end
                ACC: if (ifm_valid) begin
                    for (int i = 0; i < DSP_NO; i++)
                        acc[i] <= (kernel_addr == '0) ? term[i]
                                                      : acc[i] + term[i];
                    kernel_addr <= last_tap ? '0 : kernel_addr + 1'b1;
                end
                REQ: for (int i = 0; i < DSP_NO; i++)
                    ofm[i*WIDTH +: WIDTH] <= rq[i];
                OUT: if (ofm_ready && !last_pix) pixel <= pixel + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fire_expand3_engine.sv
// Randomised bench for fire_expand3_engine against an arithmetic
// reference of the convolution, bias, ReLU and saturation rules.
module tb_fire_expand3_engine;

    localparam int W    = 16;
    localparam int DN   = 4;
    localparam int TAPS = 18;
    localparam int PIX  = 4;
    localparam int NL   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [0:0]      layer_sel;
    logic [0:0]      cur_layer;
    logic            busy, done;
    logic [W-1:0]    ifm;
    logic            ifm_valid, ifm_ready;
    logic [4:0]      kernel_addr;
    logic [DN*W-1:0] kernels;
    logic [DN*2*W-1:0] bias;
    logic [DN*W-1:0] ofm;
    logic            ofm_valid, ofm_ready;

    logic signed [W-1:0]   img  [PIX][TAPS];
    logic signed [W-1:0]   rom  [NL][TAPS][DN];
    logic signed [2*W-1:0] brom [NL][DN];

    int checks = 0;
    int failures = 0;

    fire_expand3_engine #(
        .WIDTH(16), .FRAC(14), .DSP_NO(DN), .CHIN(2),
        .KERNEL_DIM(3), .WOUT(2), .NLAYERS(NL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel),
        .cur_layer(cur_layer), .busy(busy), .done(done),
        .ifm(ifm), .ifm_valid(ifm_valid), .ifm_ready(ifm_ready),
        .kernel_addr(kernel_addr), .kernels(kernels), .bias(bias),
        .ofm(ofm), .ofm_valid(ofm_valid), .ofm_ready(ofm_ready)
    );

    always #5 clk = ~clk;

    // Combinational weight/bias ROMs addressed by the engine.
    always_comb begin
        for (int c = 0; c < DN; c++) begin
            kernels[c*W +: W] = (kernel_addr < TAPS) ?
                rom[cur_layer][kernel_addr][c] : '0;
            bias[c*2*W +: 2*W] = brom[cur_layer][c];
        end
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(int l, int p, int c);
        longint s;
        s = longint'(brom[l][c]);
        for (int t = 0; t < TAPS; t++)
            s += longint'(img[p][t]) * longint'(rom[l][t][c]);
        if (s < 0) return '0;
        s = s >>> 14;
        if (s > 32767) return 16'h7fff;
        return s[W-1:0];
    endfunction

    task automatic set_const(logic [W-1:0] iv, logic [W-1:0] kv,
                             logic [2*W-1:0] b0, logic [2*W-1:0] b1);
        for (int p = 0; p < PIX; p++)
            for (int t = 0; t < TAPS; t++) img[p][t] = iv;
        for (int l = 0; l < NL; l++)
            for (int t = 0; t < TAPS; t++)
                for (int c = 0; c < DN; c++) rom[l][t][c] = kv;
        for (int c = 0; c < DN; c++) begin
            brom[0][c] = b0;
            brom[1][c] = b1;
        end
    endtask

    task automatic set_rand();
        for (int p = 0; p < PIX; p++)
            for (int t = 0; t < TAPS; t++)
                img[p][t] = W'($urandom_range(0, 4095)) - 16'd2048;
        for (int l = 0; l < NL; l++) begin
            for (int t = 0; t < TAPS; t++)
                for (int c = 0; c < DN; c++)
                    rom[l][t][c] = W'($urandom_range(0, 4095)) - 16'd1900;
            for (int c = 0; c < DN; c++)
                brom[l][c] = 32'($urandom_range(0, 32'h0400_0000))
                             - 32'h0200_0000;
        end
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_irdy"}, 64'(ifm_ready), 64'd0);
        check({tag, "_ovld"}, 64'(ofm_valid), 64'd0);
        check({tag, "_kaddr"}, 64'(kernel_addr), 64'd0);
        check({tag, "_layer"}, 64'(cur_layer), 64'd0);
        check({tag, "_ofm"}, 64'(ofm), 64'd0);
    endtask

    task automatic run(int layer, bit stall_ifm, int stall_ofm, bit abort);
        int pix, tap, ost, cyc;
        bit fin;
        start = 1'b1;
        layer_sel = 1'(layer);
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_irdy", 64'(ifm_ready), 64'd1);
        check("start_layer", 64'(cur_layer), 64'(layer));
        pix = 0; tap = 0; ost = stall_ofm; cyc = 0; fin = 0;
        while (!fin && cyc < 3000) begin
            ifm_valid = 1'b0;
            ofm_ready = 1'b0;
            start = 1'b0;
            if (abort && ifm_ready && pix == 1 && tap == 7) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check_reset_vals("abort");
                rst = 1'b0;
                return;
            end
            if ($urandom_range(0, 7) == 0) begin
                start = 1'b1;
                layer_sel = 1'(1 - layer);
            end
            if (ifm_ready) begin
                check("kaddr", 64'(kernel_addr), 64'(tap));
                if (!stall_ifm || $urandom_range(0, 2) != 0) begin
                    ifm_valid = 1'b1;
                    ifm = img[pix][tap];
                    tap++;
                end else begin
                    ifm = W'($urandom);
                end
            end
            if (ofm_valid) begin
                check("out_irdy", 64'(ifm_ready), 64'd0);
                check("out_layer", 64'(cur_layer), 64'(layer));
                for (int c = 0; c < DN; c++)
                    check(ost > 0 ? "ofm_hold" : "ofm",
                          64'(ofm[c*W +: W]), 64'(model(layer, pix, c)));
                if (ost > 0) begin
                    ost--;
                end else begin
                    ofm_ready = 1'b1;
                    pix++;
                    tap = 0;
                    ost = stall_ofm;
                    if (pix == PIX) fin = 1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        ifm_valid = 1'b0;
        ofm_ready = 1'b0;
        if (!fin) begin
            check("timeout", 64'd0, 64'd1);
            start = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        // Start arriving together with done must be ignored.
        start = 1'b1;
        layer_sel = 1'(1 - layer);
        check("done_pulse", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check("done_low", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_layer", 64'(cur_layer), 64'(layer));
        check("idle_ofm", 64'(ofm[W-1:0]), 64'(model(layer, PIX-1, 0)));
        @(posedge clk); #1;
        check("no_restart", 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        layer_sel = '0;
        ifm = '0;
        ifm_valid = 1'b0;
        ofm_ready = 1'b0;
        set_const(16'h0, 16'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        set_const(16'h0400, 16'h0400, 32'h0, 32'h0);
        run(0, 0, 0, 0);
        check("basic_const", 64'(ofm[W-1:0]), 64'h0480);

        set_const(16'h0400, 16'h0400, 32'h0, 32'h1000_0000);
        run(1, 0, 0, 0);
        check("bias_const", 64'(ofm[3*W +: W]), 64'h4480);

        set_const(16'h0400, 16'hFC00, 32'h0, 32'h0);
        run(0, 0, 0, 0);
        check("relu_const", 64'(ofm[W-1:0]), 64'h0000);

        set_const(16'h4000, 16'h4000, 32'h0, 32'h0);
        run(0, 0, 0, 0);
        check("sat_const", 64'(ofm[2*W +: W]), 64'h7FFF);

        set_rand();
        run(0, 0, 0, 0);
        run(0, 1, 5, 0);
        run(1, 1, 5, 0);

        set_rand();
        run(1, 1, 0, 1);
        run(1, 0, 0, 0);
        run(0, 1, 2, 0);

        for (int k = 0; k < 3; k++) begin
            set_rand();
            run(k % 2, 1, $urandom_range(0, 3), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
